// File: rtl/fp32_accumulator_if.sv
// Operand-in / sum-out handshake bundle for the FP32 accumulator.
// The producer/consumer side uses master, the accumulator uses slave.
interface fp32_accumulator_if #(
  parameter int CNT_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp32_accumulator.sv
// Multi-cycle FP32 accumulator: sums a group of products (truncating, no denormals)
// and presents the group total with its term count over a valid/ready handshake.
module fp32_accumulator #(
  parameter int CNT_W = 10
) (
  input logic               clk,
  input logic               reset,
  fp32_accumulator_if.slave bus
);

  typedef enum logic [2:0] {WAIT, ALIGN, ADD, NORM, DONE} state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [31:0]      b_reg;
  logic             last_reg;
  logic [CNT_W-1:0] count;
  logic [26:0]      x_mant;
  logic [26:0]      y_mant;
  logic [7:0]       big_exp;
  logic             big_sign;
  logic             sub_op;
  logic [27:0]      sum_reg;
  logic             out_valid_r;
  logic [31:0]      out_data_r;
  logic [CNT_W-1:0] out_count_r;

  assign bus.in_ready  = (state == WAIT);
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_count = out_count_r;

  // Returns the leading-zero count of a 27-bit magnitude (27 when zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // Alignment: zero-exponent operands count as magnitude zero so they never become X.
  logic        a_zero, b_zero, a_big;
  logic [30:0] a_key, b_key;
  logic [31:0] x_op, y_op;
  logic [26:0] x_m, y_m, y_shift;
  logic [7:0]  exp_diff;

  always_comb begin
    a_zero   = (acc[30:23] == 8'd0);
    b_zero   = (b_reg[30:23] == 8'd0);
    a_key    = a_zero ? 31'd0 : acc[30:0];
    b_key    = b_zero ? 31'd0 : b_reg[30:0];
    a_big    = (a_key >= b_key);
    x_op     = a_big ? acc : b_reg;
    y_op     = a_big ? b_reg : acc;
    x_m      = ((a_big ? a_zero : b_zero)) ? 27'd0 : {1'b1, x_op[22:0], 3'b000};
    y_m      = ((a_big ? b_zero : a_zero)) ? 27'd0 : {1'b1, y_op[22:0], 3'b000};
    exp_diff = x_op[30:23] - y_op[30:23];
    y_shift  = (exp_diff >= 8'd27) ? 27'd0 : (y_m >> exp_diff);
  end

  // Normalisation works in a 10-bit signed-style exponent so under/overflow are visible.
  logic [4:0]  lzc;
  logic [9:0]  exp_n;
  logic [22:0] man_n;
  logic [31:0] norm_result;

  always_comb begin
    lzc         = lzc27(sum_reg[26:0]);
    exp_n       = 10'd0;
    man_n       = 23'd0;
    norm_result = 32'h0;
    if (sum_reg[27]) begin
      exp_n = {2'b00, big_exp} + 10'd1;
      man_n = sum_reg[26:4];
    end else begin
      exp_n = {2'b00, big_exp} - {5'd0, lzc};
      man_n = 23'((sum_reg[25:0] << lzc) >> 3);
    end
    if (sum_reg == 28'd0 || exp_n[9] || exp_n == 10'd0)
      norm_result = 32'h0;
    else if (exp_n > 10'd254)
      norm_result = {big_sign, 31'h7F7FFFFF};
    else
      norm_result = {big_sign, exp_n[7:0], man_n};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT;
      acc         <= 32'h0;
      b_reg       <= 32'h0;
      last_reg    <= 1'b0;
      count       <= '0;
      x_mant      <= 27'd0;
      y_mant      <= 27'd0;
      big_exp     <= 8'd0;
      big_sign    <= 1'b0;
      sub_op      <= 1'b0;
      sum_reg     <= 28'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0;
      out_count_r <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (bus.in_valid) begin
            b_reg    <= bus.in_data;
            last_reg <= bus.in_last;
            count    <= (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          x_mant   <= x_m;
          y_mant   <= y_shift;
          big_exp  <= x_op[30:23];
          big_sign <= x_op[31];
          sub_op   <= x_op[31] ^ y_op[31];
          state    <= ADD;
        end
        ADD: begin
          sum_reg <= sub_op ? ({1'b0, x_mant} - {1'b0, y_mant})
                            : ({1'b0, x_mant} + {1'b0, y_mant});
          state   <= NORM;
        end
        NORM: begin
          acc <= norm_result;
          if (last_reg) begin
            out_data_r  <= norm_result;
            out_count_r <= count;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            acc         <= 32'h0;
            count       <= '0;
            state       <= WAIT;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_accumulator.sv
// Directed-vector bench for fp32_accumulator: group sums, cancellation, back-pressure,
// saturation and mid-group reset, each with hand-computed expected results.
module tb_fp32_accumulator;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fp32_accumulator_if #(.CNT_W(10)) bus();

  fp32_accumulator #(.CNT_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand and holds it until the accumulator takes it; returns 1ns after the accept edge.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL send_accept: in_ready=%b after %0d cycles, required 1 (data %h)", bus.in_ready, n, d);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take_result(input logic [31:0] exp_data, input logic [9:0] exp_count, input string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_valid: out_valid=%b after %0d cycles, required 1", name, bus.out_valid, n);
    end
    checks++;
    if (bus.out_data !== exp_data) begin
      failures++;
      $display("[TB] FAIL %s_data: out_data=%h, required %h", name, bus.out_data, exp_data);
    end
    checks++;
    if (bus.out_count !== exp_count) begin
      failures++;
      $display("[TB] FAIL %s_count: out_count=%0d, required %0d", name, bus.out_count, exp_count);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_release: out_valid=%b in_ready=%b, required 0 and 1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    checks++;
    if (bus.out_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_out_data: got %h, required 00000000", bus.out_data);
    end
    checks++;
    if (bus.out_count !== 10'd0) begin
      failures++;
      $display("[TB] FAIL reset_out_count: got %0d, required 0", bus.out_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // 1.0 + 2.0 + 0.5 = 3.5; also pins down the accept-to-valid latency.
  task automatic test_group_sum();
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h3F000000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sum_early_valid: out_valid=%b two edges after last accept, required 0", bus.out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sum_latency: out_valid=%b four edges after last accept, required 1", bus.out_valid);
    end
    take_result(32'h40600000, 10'd3, "sum");
  endtask

  task automatic test_cancel();
    send(32'h40400000, 1'b0);
    send(32'hC0400000, 1'b1);
    take_result(32'h00000000, 10'd2, "cancel");
    send(32'h3F800000, 1'b1);
    take_result(32'h3F800000, 10'd1, "after_cancel");
  endtask

  // 1.0 - 0.25 = 0.75, and -1.0 + 0.25 = -0.75.
  task automatic test_mixed_signs();
    send(32'h3F800000, 1'b0);
    send(32'hBE800000, 1'b1);
    take_result(32'h3F400000, 10'd2, "sub_pos");
    send(32'hBF800000, 1'b0);
    send(32'h3E800000, 1'b1);
    take_result(32'hBF400000, 10'd2, "sub_neg");
  endtask

  task automatic test_back_pressure();
    send(32'h40000000, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F800000;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h40000000) begin
        failures++;
        $display("[TB] FAIL hold_result[%0d]: out_valid=%b out_data=%h, required 1 and 40000000", i, bus.out_valid, bus.out_data);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_in_ready[%0d]: in_ready=%b, required 0", i, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take_result(32'h40000000, 10'd1, "held");
    send(32'h3F000000, 1'b1);
    take_result(32'h3F000000, 10'd1, "after_hold");
  endtask

  task automatic test_saturation();
    send(32'h7F7FFFFF, 1'b0);
    send(32'h7F7FFFFF, 1'b1);
    take_result(32'h7F7FFFFF, 10'd2, "saturate");
    send(32'h3F800000, 1'b0);
    send(32'h00000000, 1'b1);
    take_result(32'h3F800000, 10'd2, "add_zero");
  endtask

  task automatic test_reset_mid_group();
    int seen;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("[TB] FAIL midreset_valid: out_valid high in %0d cycles, required 0", seen);
    end
    checks++;
    if (bus.out_data !== 32'h0 || bus.out_count !== 10'd0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: out_data=%h out_count=%0d, required 00000000 and 0", bus.out_data, bus.out_count);
    end
    send(32'h40A00000, 1'b1);
    take_result(32'h40A00000, 10'd1, "after_midreset");
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_group_sum();
    test_cancel();
    test_mixed_signs();
    test_back_pressure();
    test_saturation();
    test_reset_mid_group();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
